register_bank_16x32_write: RTL and testbench

- Write side of the 16-entry, 32-bit ARM general register file.
- A 4-to-16 write-address decoder selects one of sixteen 32-bit registers R0–R15, which are loaded on the clock edge.
- All sixteen register contents are exposed in parallel and feed the existing 16:1 32-bit read multiplexers (ports A..P).
- R15 (PC) also has a dedicated sequential-update port, used by the fetch stage.

---
 rtl/register_bank_16x32_write.sv | 100 ++++++++++
 tb/tb_register_bank_16x32_write.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/register_bank_16x32_write.sv
// Write side of the 16 x 32 ARM general register file.
// Decodes the writeback address into a one-hot load strobe and holds R0..R15.
// R15 (PC) can also be loaded from the fetch stage; a writeback to R15 wins.
module register_bank_16x32_write #(
  parameter int unsigned         DATA_W    = 32,
  parameter logic [DATA_W-1:0]   PC_RESET  = 32'h0000_0000,
  parameter logic [DATA_W-1:0]   GPR_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              LE,
  input  logic [3:0]        WA,
  input  logic [DATA_W-1:0] PW,
  input  logic              PCLE,
  input  logic [DATA_W-1:0] PCIN,
  output logic [DATA_W-1:0] Q0,
  output logic [DATA_W-1:0] Q1,
  output logic [DATA_W-1:0] Q2,
  output logic [DATA_W-1:0] Q3,
  output logic [DATA_W-1:0] Q4,
  output logic [DATA_W-1:0] Q5,
  output logic [DATA_W-1:0] Q6,
  output logic [DATA_W-1:0] Q7,
  output logic [DATA_W-1:0] Q8,
  output logic [DATA_W-1:0] Q9,
  output logic [DATA_W-1:0] Q10,
  output logic [DATA_W-1:0] Q11,
  output logic [DATA_W-1:0] Q12,
  output logic [DATA_W-1:0] Q13,
  output logic [DATA_W-1:0] Q14,
  output logic [DATA_W-1:0] Q15,
  output logic [15:0]       WR_HIT
);

  logic [DATA_W-1:0] regs_q [16];
  logic [15:0]       dec;
  logic [15:0]       wr_hit_q;

  // Write-address decoder; WA is ignored entirely when LE is low so X on WA is harmless.
  always_comb begin
    dec = '0;
    if (LE) begin
      dec[WA] = 1'b1;
    end
  end

  // General-purpose registers R0..R14: load on decoded strobe, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < 15; n++) begin
        regs_q[n] <= GPR_RESET;
      end
    end else begin
      for (int n = 0; n < 15; n++) begin
        if (dec[n]) begin
          regs_q[n] <= PW;
        end
      end
    end
  end

  // R15: an explicit instruction write overrides the fetch-stage PC update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q[15] <= PC_RESET;
    end else if (dec[15]) begin
      regs_q[15] <= PW;
    end else if (PCLE) begin
      regs_q[15] <= PCIN;
    end
  end

  // Write-hit flags: one cycle pulse per LE write, never set by PCLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_hit_q <= '0;
    end else begin
      wr_hit_q <= dec;
    end
  end

  assign Q0     = regs_q[0];
  assign Q1     = regs_q[1];
  assign Q2     = regs_q[2];
  assign Q3     = regs_q[3];
  assign Q4     = regs_q[4];
  assign Q5     = regs_q[5];
  assign Q6     = regs_q[6];
  assign Q7     = regs_q[7];
  assign Q8     = regs_q[8];
  assign Q9     = regs_q[9];
  assign Q10    = regs_q[10];
  assign Q11    = regs_q[11];
  assign Q12    = regs_q[12];
  assign Q13    = regs_q[13];
  assign Q14    = regs_q[14];
  assign Q15    = regs_q[15];
  assign WR_HIT = wr_hit_q;

endmodule

// File: tb/tb_register_bank_16x32_write.sv
// Directed bench for register_bank_16x32_write with a small reference array.
module tb_register_bank_16x32_write;

  logic        clk;
  logic        reset_n;
  logic        LE;
  logic [3:0]  WA;
  logic [31:0] PW;
  logic        PCLE;
  logic [31:0] PCIN;
  logic [31:0] q [16];
  logic [15:0] wr_hit;

  logic [31:0] exp_q [16];
  int          errors;
  int          checks;

  register_bank_16x32_write #(
    .DATA_W    (32),
    .PC_RESET  (32'h0000_0100),
    .GPR_RESET (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .LE      (LE),
    .WA      (WA),
    .PW      (PW),
    .PCLE    (PCLE),
    .PCIN    (PCIN),
    .Q0      (q[0]),
    .Q1      (q[1]),
    .Q2      (q[2]),
    .Q3      (q[3]),
    .Q4      (q[4]),
    .Q5      (q[5]),
    .Q6      (q[6]),
    .Q7      (q[7]),
    .Q8      (q[8]),
    .Q9      (q[9]),
    .Q10     (q[10]),
    .Q11     (q[11]),
    .Q12     (q[12]),
    .Q13     (q[13]),
    .Q14     (q[14]),
    .Q15     (q[15]),
    .WR_HIT  (wr_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] want_hit);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s q%0d", tag, i), q[i], exp_q[i]);
    end
    check($sformatf("%s wr_hit", tag), {16'h0, wr_hit}, {16'h0, want_hit});
  endtask

  task automatic reset_model();
    for (int i = 0; i < 15; i++) begin
      exp_q[i] = 32'h0;
    end
    exp_q[15] = 32'h0000_0100;
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b1;
    LE      = 1'b0;
    WA      = 4'h0;
    PW      = 32'h0;
    PCLE    = 1'b0;
    PCIN    = 32'h0;
    reset_model();

    // 1. Reset values, and writes ignored while reset is held.
    #2 reset_n = 1'b0;
    #1;
    check_all("reset", 16'h0);
    LE = 1'b1;
    WA = 4'd3;
    PW = 32'hDEAD_BEEF;
    PCLE = 1'b1;
    PCIN = 32'h0000_0F00;
    step();
    step();
    check_all("reset_hold", 16'h0);
    reset_n = 1'b1;
    LE      = 1'b0;
    PCLE    = 1'b0;

    // 2. Walking writes across all sixteen registers.
    for (int n = 0; n < 16; n++) begin
      LE = 1'b1;
      WA = 4'(n);
      PW = 32'h1111_0000 + 32'(n);
      step();
      exp_q[n] = 32'h1111_0000 + 32'(n);
      check_all($sformatf("walk%0d", n), 16'(1) << n);
    end
    LE = 1'b0;
    step();
    check_all("walk_readback", 16'h0);

    // 3. Writeback to R15 beats a same-cycle PC update; then PC update alone.
    LE   = 1'b1;
    WA   = 4'd15;
    PW   = 32'h0000_8000;
    PCLE = 1'b1;
    PCIN = 32'h0000_0004;
    step();
    exp_q[15] = 32'h0000_8000;
    check_all("pc_prio", 16'h8000);
    LE   = 1'b0;
    PCIN = 32'h0000_8004;
    step();
    exp_q[15] = 32'h0000_8004;
    check_all("pc_only", 16'h0);

    // 4. Independent GPR write and PC update in one cycle.
    LE   = 1'b1;
    WA   = 4'd7;
    PW   = 32'hA5A5_A5A5;
    PCLE = 1'b1;
    PCIN = 32'h0000_0020;
    step();
    exp_q[7]  = 32'hA5A5_A5A5;
    exp_q[15] = 32'h0000_0020;
    check_all("concurrent", 16'h0080);

    // 5. Hold with LE low, unknown address and all-ones data.
    LE   = 1'b0;
    PCLE = 1'b0;
    WA   = 4'bxxxx;
    PW   = 32'hFFFF_FFFF;
    for (int c = 0; c < 10; c++) begin
      step();
      check_all($sformatf("hold%0d", c), 16'h0);
    end

    // 6. Asynchronous reset between edges clears everything at once.
    LE = 1'b1;
    WA = 4'd5;
    PW = 32'h1234_5678;
    step();
    exp_q[5] = 32'h1234_5678;
    check_all("load_r5", 16'h0020);
    LE = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    reset_model();
    check_all("async_rst", 16'h0);
    #2 reset_n = 1'b1;
    step();
    check_all("after_rst", 16'h0);

    // Reset spanning an edge drops the write presented on that edge.
    LE = 1'b1;
    WA = 4'd9;
    PW = 32'hCAFE_F00D;
    @(negedge clk);
    #3 reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_edge", 16'h0);
    reset_n = 1'b1;
    LE      = 1'b0;
    #1;
    check_all("rst_edge_rel", 16'h0);
    step();
    check_all("rst_edge_post", 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
